// File: rtl/parking_lane_arbiter.sv
// Two-lane entry arbiter in front of a shared gate/PIN controller, with lot occupancy tracking.
// Define LANE_FIXED_PRIORITY_EN to make lane 0 win every tie instead of round-robin.
module parking_lane_arbiter #(
  parameter int unsigned CAPACITY = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             done,
  input  logic             abort,
  input  logic             exitEvent,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             timeoutAlarm
);

  localparam int unsigned TmrW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StServe, StRelease} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             last_q, last_d;  // 1 when lane 1 was the most recently served lane
  logic [TmrW-1:0]  timer_q, timer_d;
  logic [1:0]       pick;
  logic             car_in;
  logic             at_cap;
  logic             at_zero;

  always_comb begin
    pick = {req1, req0};
    if (req0 && req1) begin
`ifdef LANE_FIXED_PRIORITY_EN
      pick = 2'b01;
`else
      pick = last_q ? 2'b01 : 2'b10;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    timer_d = timer_q;
    last_d  = last_q;
    alarm_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!full_q && (req0 || req1)) begin
          state_d = StServe;
          grant_d = pick;
          busy_d  = 1'b1;
          timer_d = '0;
        end
      end
      StServe: begin
        timer_d = timer_q + 1'b1;
        if (done || abort || (timer_q == TmrW'(TIMEOUT - 1))) begin
          state_d = StRelease;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          last_d  = grant_q[1];
          // A done/abort racing the timeout wins; only a bare expiry raises the alarm.
          alarm_d = !done && !abort;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign car_in  = (state_q == StServe) && done;
  assign at_cap  = (count_q == CNT_W'(CAPACITY));
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (car_in && exitEvent) begin
      count_d = count_q;
    end else if (car_in && !at_cap) begin
      count_d = count_q + 1'b1;
    end else if (exitEvent && !at_zero) begin
      count_d = count_q - 1'b1;
    end
    full_d = (count_d == CNT_W'(CAPACITY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      count_q <= '0;
      alarm_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      count_q <= count_d;
      alarm_q <= alarm_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign full         = full_q;
  assign count        = count_q;
  assign timeoutAlarm = alarm_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter: expected status words are queued per step and
// popped for comparison one clock later.
module tb_parking_lane_arbiter;

  logic       clk = 1'b0;
  logic       reset, req0, req1, done, abort, exitEvent;
  logic [1:0] grant;
  logic       busy, full, timeoutAlarm;
  logic [3:0] count;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string      tag;
    logic [8:0] st;
  } exp_t;

  exp_t sb[$];

  parking_lane_arbiter #(
    .CAPACITY(8),
    .CNT_W   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .done        (done),
    .abort       (abort),
    .exitEvent   (exitEvent),
    .grant       (grant),
    .busy        (busy),
    .full        (full),
    .count       (count),
    .timeoutAlarm(timeoutAlarm)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Queue the expected status, advance one clock, then compare against the DUT.
  task automatic cyc(input string tag, input logic [1:0] g, input logic b, input logic f,
                     input logic [3:0] c, input logic a);
    exp_t e;
    logic [8:0] obs;
    e.tag = tag;
    e.st  = {g, b, f, c, a};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {grant, busy, full, count, timeoutAlarm};
    checks++;
    assert (obs === e.st)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (grant,busy,full,count,alarm)", e.tag, obs,
             e.st);
    end
  endtask

  logic [1:0] rr_lane[3];
  logic [3:0] c;

  initial begin
`ifdef LANE_FIXED_PRIORITY_EN
    rr_lane = '{2'b01, 2'b01, 2'b01};
`else
    rr_lane = '{2'b10, 2'b01, 2'b10};
`endif
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0; abort = 1'b0; exitEvent = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;

    // Single request on lane 0, done three cycles into SERVE.
    req0 = 1'b1;
    cyc("grant0", 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    req0 = 1'b0;
    cyc("hold0", 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc("hold0", 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    done = 1'b1;
    cyc("done0", 2'b00, 1'b0, 1'b0, 4'd1, 1'b0);
    done = 1'b0;
    cyc("idle0", 2'b00, 1'b0, 1'b0, 4'd1, 1'b0);

    // Both lanes held: tie-break after lane 0 was served last.
    req0 = 1'b1; req1 = 1'b1;
    c = 4'd1;
    for (int i = 0; i < 3; i++) begin
      cyc("rr_grant", rr_lane[i], 1'b1, 1'b0, c, 1'b0);
      done = 1'b1;
      cyc("rr_release", 2'b00, 1'b0, 1'b0, c + 4'd1, 1'b0);
      done = 1'b0;
      cyc("rr_idle", 2'b00, 1'b0, 1'b0, c + 4'd1, 1'b0);
      c = c + 4'd1;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Lane 1 held with no done/abort: forced release after 16 SERVE cycles.
    req1 = 1'b1;
    cyc("to_grant", 2'b10, 1'b1, 1'b0, 4'd4, 1'b0);
    req1 = 1'b0;
    repeat (15) cyc("to_hold", 2'b10, 1'b1, 1'b0, 4'd4, 1'b0);
    cyc("to_alarm", 2'b00, 1'b0, 1'b0, 4'd4, 1'b1);
    cyc("to_idle", 2'b00, 1'b0, 1'b0, 4'd4, 1'b0);

    // Abort leaves count alone; done+abort together counts the car.
    req0 = 1'b1;
    cyc("ab_grant", 2'b01, 1'b1, 1'b0, 4'd4, 1'b0);
    req0 = 1'b0; abort = 1'b1;
    cyc("ab_release", 2'b00, 1'b0, 1'b0, 4'd4, 1'b0);
    abort = 1'b0;
    cyc("ab_idle", 2'b00, 1'b0, 1'b0, 4'd4, 1'b0);
    req1 = 1'b1;
    cyc("da_grant", 2'b10, 1'b1, 1'b0, 4'd4, 1'b0);
    req1 = 1'b0; done = 1'b1; abort = 1'b1;
    cyc("da_release", 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);
    done = 1'b0; abort = 1'b0;
    cyc("da_idle", 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);

    // done with a simultaneous exit at count 5 nets to zero.
    req0 = 1'b1;
    cyc("dx_grant", 2'b01, 1'b1, 1'b0, 4'd5, 1'b0);
    req0 = 1'b0; done = 1'b1; exitEvent = 1'b1;
    cyc("dx_release", 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);
    done = 1'b0; exitEvent = 1'b0;
    cyc("dx_idle", 2'b00, 1'b0, 1'b0, 4'd5, 1'b0);

    // Fill the lot to capacity.
    for (int k = 0; k < 3; k++) begin
      req0 = 1'b1;
      cyc("fill_grant", 2'b01, 1'b1, 1'b0, 4'(5 + k), 1'b0);
      req0 = 1'b0; done = 1'b1;
      cyc("fill_release", 2'b00, 1'b0, (k == 2), 4'(6 + k), 1'b0);
      done = 1'b0;
      cyc("fill_idle", 2'b00, 1'b0, (k == 2), 4'(6 + k), 1'b0);
    end

    // Full lot blocks requests; a stray done outside SERVE is ignored.
    req0 = 1'b1;
    cyc("full_block", 2'b00, 1'b0, 1'b1, 4'd8, 1'b0);
    cyc("full_block", 2'b00, 1'b0, 1'b1, 4'd8, 1'b0);
    done = 1'b1;
    cyc("done_outside", 2'b00, 1'b0, 1'b1, 4'd8, 1'b0);
    done = 1'b0; exitEvent = 1'b1;
    cyc("exit_unfull", 2'b00, 1'b0, 1'b0, 4'd7, 1'b0);
    exitEvent = 1'b0;
    cyc("refill_grant", 2'b01, 1'b1, 1'b0, 4'd7, 1'b0);
    req0 = 1'b0;

    // Reset in the middle of SERVE, then exit at an empty lot.
    reset = 1'b1;
    cyc("rst_serve", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0; exitEvent = 1'b1;
    cyc("exit_zero", 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
    exitEvent = 1'b0;

    // done on the last allowed SERVE cycle is honoured without an alarm.
    req0 = 1'b1;
    cyc("race_grant", 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    req0 = 1'b0;
    repeat (15) cyc("race_hold", 2'b01, 1'b1, 1'b0, 4'd0, 1'b0);
    done = 1'b1;
    cyc("race_done", 2'b00, 1'b0, 1'b0, 4'd1, 1'b0);
    done = 1'b0;
    cyc("race_idle", 2'b00, 1'b0, 1'b0, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/parking_lane_arbiter.md
Name: parking_lane_arbiter

Overview:
- Arbitrates two entry lanes (lane 0, lane 1) that share one parkingmanager gate/PIN controller.
- Grants at most one lane at a time and holds the grant until the gate controller reports pass, abort or timeout.
- Tracks lot occupancy and refuses new grants when the lot is full.
- Sits between the lane sensorA inputs and the shared parkingmanager instance, and drives the lane-select mux.

Parameters:
CAPACITY, 8, maximum cars in the lot; full asserts when count equals CAPACITY.
CNT_W, 4, width of the occupancy counter; must satisfy 2^CNT_W > CAPACITY.
TIMEOUT, 16, cycles a grant may be held without done or abort before forced release; must be at least 2.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req0  input  1  lane 0 car present (lane sensorA), level.
req1  input  1  lane 1 car present (lane sensorA), level.
done  input  1  one-cycle pulse from the gate controller: the granted car has passed the gate.
abort  input  1  one-cycle pulse from the gate controller: the grant ended with no entry (wrong-PIN block or car backed out).
exitEvent  input  1  one-cycle pulse: a car left the lot through the exit.
grant  output  2  one-hot lane grant; bit0 is lane 0, bit1 is lane 1; 2'b00 when no grant is active.
busy  output  1  high while in SERVE.
full  output  1  high when count == CAPACITY.
count  output  CNT_W  current occupancy.
timeoutAlarm  output  1  one-cycle pulse when a grant is force-released by timeout.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: grant=2'b00, busy=0, full=0, count=0, timeoutAlarm=0, state=IDLE, lastServed=1 (lane 0 wins the first tie), timer=0.
- FSM states: IDLE, SERVE, RELEASE.
- IDLE:
  - If !full and (req0|req1), go to SERVE, load grant and clear timer on the same edge. The grant is visible one cycle after the request is sampled.
  - A single request is granted to its own lane.
  - When both lanes request, grant the lane != lastServed (round-robin).
  - While full, requests are ignored and the FSM stays in IDLE.
- SERVE:
  - grant is held constant even if the request drops. timer increments every cycle.
  - done has priority over abort:
    - done: count+1, lastServed = granted lane, go to RELEASE.
    - abort alone: count unchanged, lastServed = granted lane, go to RELEASE.
  - If timer == TIMEOUT-1 with no done or abort: timeoutAlarm pulses for 1 cycle, lastServed = granted lane, go to RELEASE.
  - done or abort arriving in the same cycle as the timeout is honoured; no alarm is raised.
- RELEASE:
  - grant=00 and busy=0 for exactly 1 cycle, which guarantees a dead cycle on the lane mux. Then go to IDLE.
- Occupancy rules, evaluated every cycle in any state:
  - exitEvent decrements count if count > 0. Exit at count == 0 is ignored, with no underflow.
  - done and exitEvent in the same cycle leave count unchanged.
  - count never exceeds CAPACITY; a done at count == CAPACITY with no exit is ignored.
  - full is registered, and is derived from the next-state value of count.
- done, abort or timeout outside SERVE: ignored, except that exitEvent is always honoured.
- Reset asserted mid-SERVE: grant drops to 00 on the next edge, count returns to 0, and there is no alarm.

Optional Feature:
- Macro: LANE_FIXED_PRIORITY_EN.
- Defined: on a tie, lane 0 always wins. lastServed is not used for arbitration; it is still updated but has no effect.
- Undefined (default): round-robin tie-break as described in Behaviour.

Test Plan:
- Reset, then req0=1 for 1 cycle -> grant=01 on the next cycle, busy=1. Pulse done 3 cycles later -> count=1, followed by one cycle of grant=00, then IDLE.
- req0=req1=1 held -> grants alternate: 01 (done), 00, 10 (done), 00, 01. With LANE_FIXED_PRIORITY_EN defined -> 01, 00, 01, ...
- Grant lane 1 with no done or abort and TIMEOUT=16 -> timeoutAlarm pulses on the 16th cycle of SERVE, grant=00, count unchanged.
- Fill to count=8 -> full=1, req0 held gives no grant. Pulse exitEvent -> count=7, full=0, grant=01 two cycles after the exit.
- done and exitEvent in the same cycle at count=5 -> count stays 5. exitEvent at count=0 -> count stays 0. done and abort together -> count+1.
- Assert reset during SERVE at count=3 -> grant=00, count=0, busy=0 after the next edge, and no timeoutAlarm.
